// File: rtl/pattern_scan_scheduler.sv
// Round-robin time-multiplexed overlapping pattern detector over NCH bit-serial channels.
// Optional sticky per-channel match flags are enabled by defining PATTERN_SCAN_IRQ_EN.
module pattern_scan_scheduler #(
    parameter int NCH = 4,
    parameter int PAT_W = 5,
    parameter logic [PAT_W-1:0] DEFAULT_PATTERN = 5'b11011,
    parameter int CNT_W = 8,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic             cfg_err,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH-1:0]   in_bit,
    output logic [NCH-1:0]   in_ready,
    output logic             match_valid,
    output logic [CH_W-1:0]  match_ch,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             busy,
    output logic [NCH-1:0]   irq,
    input  logic [NCH-1:0]   irq_clr,
    output logic [1:0]       dbg_state
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pattern_q;
    logic [CH_W-1:0]   ptr_q, ptr_next, gnt_idx, rr_cand;
    logic              gnt_any, xfer, hit;
    logic [PAT_W-1:0]  hist_q [NCH];
    logic [FILL_W-1:0] fill_q [NCH];
    logic [CNT_W-1:0]  cnt_q  [NCH];
    logic [PAT_W-1:0]  hist_new;
    logic [FILL_W-1:0] fill_new;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable || cfg_we) state_d = CLEAR;
            CLEAR:   state_d = enable ? RUN : IDLE;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan from the pointer upward, wrapping; first requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        rr_cand = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_cand = CH_W'((int'(ptr_q) + k) % NCH);
            if (!gnt_any && in_valid[rr_cand]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_cand;
            end
        end
    end

    // Handshake: a bit moves on channel i when in_valid[i] & in_ready[i];
    // in_ready is only raised in RUN, one-hot, for the granted requester.
    assign xfer     = (state_q == RUN) && gnt_any;
    assign in_ready = xfer ? (NCH'(1) << gnt_idx) : '0;
    assign ptr_next = (gnt_idx == CH_W'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

    assign hist_new = {hist_q[gnt_idx][PAT_W-2:0], in_bit[gnt_idx]};
    assign fill_new = (fill_q[gnt_idx] == FILL_W'(PAT_W)) ? fill_q[gnt_idx]
                                                          : fill_q[gnt_idx] + 1'b1;
    assign hit      = xfer && (fill_new == FILL_W'(PAT_W)) && (hist_new == pattern_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pattern_q   <= DEFAULT_PATTERN;
            ptr_q       <= '0;
            match_valid <= 1'b0;
            match_ch    <= '0;
            cfg_err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cfg_we) pattern_q <= cfg_pattern;
            if (xfer) ptr_q <= ptr_next;
            match_valid <= hit;
            match_ch    <= hit ? gnt_idx : '0;
            cfg_err     <= cfg_we && (state_q != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (state_q == CLEAR) begin
            for (int i = 0; i < NCH; i++) begin
                hist_q[i] <= '0;
                fill_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (xfer) begin
            hist_q[gnt_idx] <= hist_new;
            fill_q[gnt_idx] <= fill_new;
            if (hit && cnt_q[gnt_idx] != '1) cnt_q[gnt_idx] <= cnt_q[gnt_idx] + 1'b1;
        end
    end

    assign rd_cnt    = (int'(rd_ch) < NCH) ? cnt_q[rd_ch] : '0;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

`ifdef PATTERN_SCAN_IRQ_EN
    logic [NCH-1:0] irq_q;

    // A new match outranks a simultaneous clear; CLEAR state leaves flags alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= '0;
        else     irq_q <= (irq_q & ~irq_clr) | (hit ? in_ready : '0);
    end
    assign irq = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = |irq_clr;
    assign irq = '0;
`endif

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Scoreboard bench for pattern_scan_scheduler (NCH=4, PAT_W=5, CNT_W=2); irq checks
// follow PATTERN_SCAN_IRQ_EN.
module tb_pattern_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       cfg_we;
    logic [4:0] cfg_pattern;
    logic       cfg_err;
    logic [3:0] in_valid, in_bit, in_ready;
    logic       match_valid;
    logic [1:0] match_ch;
    logic [1:0] rd_ch;
    logic [1:0] rd_cnt;
    logic       busy;
    logic [3:0] irq, irq_clr;
    logic [1:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];

    // Reference model of the channel contexts
    logic [4:0] m_pat;
    logic [4:0] m_hist[4];
    int         m_fill[4];
    int         m_cnt[4];
    logic [3:0] m_irq;

    pattern_scan_scheduler #(.NCH(4), .PAT_W(5), .DEFAULT_PATTERN(5'b11011), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_err(cfg_err), .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
        .match_valid(match_valid), .match_ch(match_ch), .rd_ch(rd_ch), .rd_cnt(rd_cnt),
        .busy(busy), .irq(irq), .irq_clr(irq_clr), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: each entry is {expected cycle, channel}
    always @(negedge clk) begin
        logic [31:0] got, exp;
        if (match_valid) begin
            got = (cyc << 4) | 32'(match_ch);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hffff_ffff;
            check("match", got, exp);
        end else begin
            check("match_ch_idle", 32'(match_ch), 0);
            if (exp_q.size() != 0 && (exp_q[0] >> 4) <= cyc) begin
                exp = exp_q.pop_front();
                check("missed_match", 0, exp);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0;
            m_fill[i] = 0;
            m_cnt[i]  = 0;
        end
    endtask

    task automatic model_reset();
        model_clear();
        m_pat = 5'b11011;
        m_irq = '0;
        exp_q.delete();
    endtask

    task automatic model_xfer(input int ch, input bit b);
        logic hit;
        m_hist[ch] = {m_hist[ch][3:0], b};
        if (m_fill[ch] < 5) m_fill[ch]++;
        hit = (m_fill[ch] == 5) && (m_hist[ch] == m_pat);
        if (hit) begin
            if (m_cnt[ch] < 3) m_cnt[ch]++;
            exp_q.push_back(((cyc + 1) << 4) | ch);
        end
`ifdef PATTERN_SCAN_IRQ_EN
        m_irq = (m_irq & ~irq_clr) | (hit ? (4'b1 << ch) : 4'b0);
`endif
    endtask

    // Driver: one bit on one channel, the only requester, so it is granted at once
    task automatic send(input int ch, input bit b);
        in_valid = '0;
        in_valid[ch] = 1'b1;
        in_bit = '0;
        in_bit[ch] = b;
        #1 check("grant", 32'(in_ready), 32'(4'b1 << ch));
        model_xfer(ch, b);
        @(negedge clk);
        in_valid = '0;
        in_bit = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        cfg_we = 1'b0;
        in_valid = '0;
        in_bit = '0;
        irq_clr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // IDLE -> CLEAR (one cycle, no grants) -> RUN
    task automatic start_run();
        enable = 1'b1;
        @(negedge clk);
        check("busy_clear", 32'(busy), 1);
        check("state_clear", 32'(dbg_state), 1);
        in_valid = '1;
        #1 check("ready_clear", 32'(in_ready), 0);
        in_valid = '0;
        model_clear();
        @(negedge clk);
        check("state_run", 32'(dbg_state), 2);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        @(negedge clk);
        check("busy_stop", 32'(busy), 0);
    endtask

    initial begin
        rd_ch = '0;
        cfg_pattern = '0;
        rst = 1'b1;
        enable = 1'b0;
        cfg_we = 1'b0;
        in_valid = '1;
        in_bit = '0;
        irq_clr = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);

        // Reset values
        check("rst_match_valid", 32'(match_valid), 0);
        check("rst_match_ch", 32'(match_ch), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_rd_cnt", 32'(rd_cnt), 0);
        check("rst_state", 32'(dbg_state), 0);
        in_valid = '0;
        rst = 1'b0;

        // Basic match on channel 0
        start_run();
        foreach (m_pat[i]) send(0, m_pat[i]);
        rd_ch = 2'd0;
        #1 check("cnt_ch0", 32'(rd_cnt), 32'(m_cnt[0]));

        // Overlapping matches on channel 2
        begin
            logic [7:0] s;
            s = 8'b11011011;
            for (int i = 7; i >= 0; i--) send(2, s[i]);
        end
        rd_ch = 2'd2;
        #1 check("cnt_ch2_overlap", 32'(rd_cnt), 2);

        // Round-robin from pointer 0 with every channel requesting
        do_reset();
        start_run();
        in_valid = '1;
        in_bit = '0;
        for (int i = 0; i < 8; i++) begin
            #1 check("rr_grant", 32'(in_ready), 32'(4'b1 << (i % 4)));
            model_xfer(i % 4, 1'b0);
            @(negedge clk);
        end
        in_valid = '0;
        #1 check("rr_none", 32'(in_ready), 0);
        send(2, 1'b0);
        send(1, 1'b0);

        // Pattern write during RUN is rejected
        cfg_we = 1'b1;
        cfg_pattern = 5'b10101;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 1);
        @(negedge clk);
        check("cfg_err_drop", 32'(cfg_err), 0);
        foreach (m_pat[i]) send(1, m_pat[i]);

        // Pattern write in IDLE, restart through CLEAR
        stop_run();
        @(negedge clk);
        check("idle_hold", 32'(dbg_state), 0);
        cfg_we = 1'b1;
        cfg_pattern = 5'b10101;
        enable = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        m_pat = 5'b10101;
        check("cfg_err_idle", 32'(cfg_err), 0);
        check("busy_rise", 32'(busy), 1);
        check("state_clear2", 32'(dbg_state), 1);
        in_valid = '1;
        #1 check("ready_clear2", 32'(in_ready), 0);
        in_valid = '0;
        model_clear();
        @(negedge clk);
        rd_ch = 2'd1;
        #1 check("cnt_cleared", 32'(rd_cnt), 0);
        foreach (m_pat[i]) send(0, m_pat[i]);
        rd_ch = 2'd0;
        #1 check("cnt_new_pat", 32'(rd_cnt), 1);

        // Saturation on channel 3; final bit arrives as enable drops
        for (int i = 0; i < 13; i++) begin
            if (i == 12) enable = 1'b0;
            send(3, (i % 2) == 0);
            if (i == 8) begin
                rd_ch = 2'd3;
                #1 check("cnt_sat3", 32'(rd_cnt), 32'(m_cnt[3]));
            end
        end
        check("busy_after_stop", 32'(busy), 0);
        rd_ch = 2'd3;
        #1 check("cnt_sat", 32'(rd_cnt), 3);

        // Reset mid-stream, then irq behaviour
        do_reset();
        start_run();
        send(0, 1'b1);
        send(0, 1'b1);
        send(0, 1'b0);
        send(0, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_match", 32'(match_valid), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_irq", 32'(irq), 0);
        rd_ch = 2'd0;
        check("mid_rst_cnt", 32'(rd_cnt), 0);
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        start_run();
        send(0, 1'b1);
        send(0, 1'b1);
        send(0, 1'b0);
        send(0, 1'b1);
        send(0, 1'b1);
        check("irq_set", 32'(irq), 32'(m_irq));
        irq_clr = 4'b0001;
        @(negedge clk);
        irq_clr = '0;
        m_irq = m_irq & 4'b1110;
        check("irq_clr", 32'(irq), 32'(m_irq));
        send(0, 1'b0);
        send(0, 1'b1);
        irq_clr = 4'b0001;
        send(0, 1'b1);
        irq_clr = '0;
        check("irq_set_wins", 32'(irq), 32'(m_irq));
        stop_run();
        start_run();
        check("irq_keep_clear", 32'(irq), 32'(m_irq));
        rd_ch = 2'd0;
        #1 check("cnt_after_restart", 32'(rd_cnt), 0);

        repeat (3) @(negedge clk);
        check("drain", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_scan_scheduler.md
Name: pattern_scan_scheduler

Overview:
Time-multiplexes one shared serial pattern-match engine across NCH independent bit-serial channels. A round-robin arbiter grants at most one channel per cycle. Per-channel context (bit history, fill level, match count) is saved in local registers, so each channel behaves like its own overlapping Moore detector for a programmable PAT_W-bit pattern. A control FSM sequences configuration, context clearing and run/stop.

Parameters:
NCH, 4, number of serial input channels (2..16)
PAT_W, 5, pattern length in bits (2..16)
DEFAULT_PATTERN, 5'b11011, pattern loaded at reset; MSB is the oldest bit
CNT_W, 8, width of each per-channel saturating match counter

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
enable  input  1  level; 1 = scan, 0 = stop
cfg_we  input  1  pattern write strobe
cfg_pattern  input  PAT_W  new pattern; MSB is the oldest bit
cfg_err  output  1  one-cycle pulse: cfg_we arrived outside IDLE and was ignored
in_valid  input  NCH  per-channel bit valid
in_bit  input  NCH  per-channel serial data bit
in_ready  output  NCH  one-hot grant; at most one bit set
match_valid  output  1  one-cycle match pulse
match_ch  output  $clog2(NCH)  channel of the current match; 0 when no match
rd_ch  input  $clog2(NCH)  counter read select
rd_cnt  output  CNT_W  match count of channel rd_ch (combinational read)
busy  output  1  1 while the FSM is in CLEAR or RUN
irq  output  NCH  sticky per-channel match flags (see Optional Feature)
irq_clr  input  NCH  write-1-to-clear for irq

Behaviour:
- Reset:
  - State = IDLE; pattern = DEFAULT_PATTERN; round-robin pointer = 0.
  - All histories, fill levels, counters and irq = 0.
  - in_ready, match_valid, match_ch, cfg_err, busy = 0.
- FSM states: IDLE, CLEAR, RUN.
  - IDLE: in_ready = 0. cfg_we loads the pattern. Next cycle goes to CLEAR if enable = 1 or cfg_we = 1.
  - CLEAR: exactly one cycle. Zeroes every history, fill level and match counter; irq is kept. in_ready = 0. Next state: RUN if enable = 1, else IDLE.
  - RUN: arbitrate and process. When enable = 0, go to IDLE the next cycle; a transfer completing in that same cycle is still processed. Contexts are kept on stop.
  - Restarting from IDLE always passes through CLEAR, so contexts are wiped on every restart.
- cfg_we while not in IDLE: the write is ignored and cfg_err pulses for 1 cycle, registered.
- Arbitration (RUN only):
  - in_ready is combinational from in_valid and the pointer.
  - The grant goes to the first requesting channel at or after the pointer, modulo NCH.
  - A transfer occurs when in_valid[i] & in_ready[i].
  - After a transfer the pointer moves to grant + 1, wrapping NCH-1 -> 0. With no transfer the pointer holds.
  - No starvation: each requester waits at most NCH-1 cycles.
- Context update on a transfer to channel i:
  - hist[i] <= {hist[i][PAT_W-2:0], in_bit[i]}.
  - fill[i] increments and saturates at PAT_W.
- Match condition: updated fill = PAT_W and updated hist = pattern.
  - History is retained after a match, so overlapping matches are detected: 11011011 gives 2 matches for 11011.
- Match outputs:
  - match_valid and match_ch are registered, 1 cycle after the transfer carrying the final bit.
  - At most one match per cycle, by construction.
- Counter: match_cnt[i] increments on each match and saturates at 2^CNT_W-1.
- Async reset mid-RUN: immediate return to reset values; any in-flight match pulse is lost.

Optional Feature:
Macro: PATTERN_SCAN_IRQ_EN.
- Defined:
  - irq[i] sets on a match on channel i, in the same cycle as match_valid.
  - irq_clr[i] = 1 clears irq[i]; a set in the same cycle wins.
  - irq survives CLEAR; only reset or irq_clr clears it.
- Not defined: irq tied to 0, irq_clr ignored, no irq flops.

Test Plan:
1. Reset defaults: enable = 1, channel 0 streams 1,1,0,1,1 with no gaps -> match_valid = 1, match_ch = 0 one cycle after the 5th bit; rd_ch = 0 gives rd_cnt = 1.
2. Overlap: channel 2 streams 11011011 -> exactly 2 match pulses, after bits 5 and 8; rd_cnt = 2; bits 1-4 produce no match because fill < PAT_W.
3. Round-robin fairness: all 4 in_valid held high for 8 cycles -> grants are 0,1,2,3,0,1,2,3, one in_ready bit per cycle; only channel 1 requesting with pointer = 3 -> granted the same cycle.
4. Config:
   - cfg_we with pattern 10101 during RUN -> cfg_err pulses and the pattern is unchanged.
   - Drop enable, write 10101 in IDLE, re-enable -> busy rises, 1 CLEAR cycle with in_ready = 0, then stream 10101 -> 1 match; counters were zeroed by CLEAR.
5. Saturation: with CNT_W = 2, drive 5 matches on channel 3 -> rd_cnt stays 3.
6. Reset mid-stream, plus irq (build with PATTERN_SCAN_IRQ_EN):
   - Assert rst after 4 bits of 11011 -> all outputs 0.
   - After release, a single final bit 1 gives no match, because fill was reset.
   - A later full match sets irq[0]; irq_clr[0] = 1 clears it next cycle; irq_clr in the same cycle as a new match leaves irq = 1.
